speaker_serializer: RTL and testbench



---
 rtl/speaker_serializer.sv | 52 +++++
 tb/tb_speaker_serializer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/speaker_serializer.sv
// speaker_serializer: I2S stereo DAC transmitter with clk-derived clocks; define SPEAKER_LJ_EN for left-justified format
module speaker_serializer #(
  parameter int AUDIO_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AUDIO_W-1:0] audio_left,
  input  logic [AUDIO_W-1:0] audio_right,
  output logic               audio_mclk,
  output logic               audio_sck,
  output logic               audio_lrck,
  output logic               audio_sdin,
  output logic               frame_strobe
);
`ifdef SPEAKER_LJ_EN
  localparam int SHIFT = 32 - AUDIO_W;
`else
  localparam int SHIFT = 31 - AUDIO_W;
`endif
  logic [8:0]         cnt_q, cnt_d;
  logic [AUDIO_W-1:0] left_q, left_d, right_q, right_d, word;
  logic [31:0]        slots;
  logic               sdin_q, sdin_d;
  // next count, sample capture at frame end, and next serial bit for slot of cnt+1 (left slot 0 bypasses the hold register)
  always_comb begin
    cnt_d   = cnt_q + 9'd1;
    left_d  = &cnt_q ? audio_left : left_q;
    right_d = &cnt_q ? audio_right : right_q;
    word    = cnt_d == '0 ? audio_left : cnt_d[8] ? right_q : left_q;
    slots   = 32'(word) << SHIFT;
    sdin_d  = &cnt_q[2:0] ? slots[~cnt_d[7:3]] : sdin_q;
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      sdin_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      sdin_q  <= sdin_d;
    end
  end
  assign audio_mclk   = cnt_q[1];
  assign audio_sck    = cnt_q[2];
  assign audio_lrck   = cnt_q[8];
  assign audio_sdin   = sdin_q;
  assign frame_strobe = &cnt_q;
endmodule

// File: tb/tb_speaker_serializer.sv
// tb_speaker_serializer: random stimulus checked cycle by cycle against a frame-level model
module tb_speaker_serializer;
  localparam int W = 16;
  logic         clk, rst_n;
  logic [W-1:0] audio_left, audio_right;
  logic         audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_strobe;
  int           mc = 0;
  logic [W-1:0] cl = '0, cr = '0;
  int           checks = 0, errors = 0;

  speaker_serializer #(.AUDIO_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .audio_left(audio_left), .audio_right(audio_right),
    .audio_mclk(audio_mclk), .audio_sck(audio_sck), .audio_lrck(audio_lrck),
    .audio_sdin(audio_sdin), .frame_strobe(frame_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_sdin(input int c, input logic [W-1:0] l, input logic [W-1:0] r);
    logic [W-1:0] d;
    int slot, b;
    d = (c >= 256) ? r : l;
    slot = (c % 256) / 8;
`ifdef SPEAKER_LJ_EN
    b = W - 1 - slot;
`else
    b = W - slot;
`endif
    if (b >= 0 && b < W) return d[b];
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d, t=%0t)", name, act, exp, mc, $time);
    end
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (mc != v && k < 600);
    if (mc != v) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: got cycle %0d expected %0d", mc, v);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc <= 0;
      cl <= '0;
      cr <= '0;
    end else begin
      if (mc == 511) begin
        cl <= audio_left;
        cr <= audio_right;
      end
      mc <= (mc + 1) % 512;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mclk", audio_mclk, logic'((mc / 2) % 2));
      chk("sck", audio_sck, logic'((mc / 4) % 2));
      chk("lrck", audio_lrck, logic'(mc / 256));
      chk("strobe", frame_strobe, logic'(mc == 511));
      chk("sdin", audio_sdin, exp_sdin(mc, cl, cr));
    end
  end

  initial begin
    rst_n = 1'b0;
    audio_left = '0;
    audio_right = '0;
    repeat (3) @(negedge clk);
    chk("rst_mclk", audio_mclk, 1'b0);
    chk("rst_sck", audio_sck, 1'b0);
    chk("rst_lrck", audio_lrck, 1'b0);
    chk("rst_sdin", audio_sdin, 1'b0);
    chk("rst_strobe", frame_strobe, 1'b0);
    rst_n = 1'b1;
    wait_cnt(1);   chk("mclk_c1", audio_mclk, 1'b0);
    wait_cnt(2);   chk("mclk_c2", audio_mclk, 1'b1);
    wait_cnt(4);   chk("sck_c4", audio_sck, 1'b1);
    wait_cnt(255); chk("lrck_c255", audio_lrck, 1'b0);
    wait_cnt(256); chk("lrck_c256", audio_lrck, 1'b1);
    wait_cnt(510); chk("strobe_c510", frame_strobe, 1'b0);
    wait_cnt(511); chk("strobe_c511", frame_strobe, 1'b1);
`ifdef SPEAKER_LJ_EN
    wait_cnt(400);
    audio_left = 16'hA5A5;
    audio_right = 16'h0000;
    wait_cnt(3);   chk("lj_slot0", audio_sdin, 1'b1);
    wait_cnt(12);  chk("lj_slot1", audio_sdin, 1'b0);
    wait_cnt(20);  chk("lj_slot2", audio_sdin, 1'b1);
    wait_cnt(124); chk("lj_slot15", audio_sdin, 1'b1);
    wait_cnt(130); chk("lj_slot16", audio_sdin, 1'b0);
`else
    wait_cnt(400);
    audio_left = 16'h8001;
    audio_right = 16'h4000;
    wait_cnt(3);   chk("i2s_l0", audio_sdin, 1'b0);
    wait_cnt(12);  chk("i2s_l1", audio_sdin, 1'b1);
    wait_cnt(20);  chk("i2s_l2", audio_sdin, 1'b0);
    wait_cnt(130); chk("i2s_l16", audio_sdin, 1'b1);
    wait_cnt(140); chk("i2s_l17", audio_sdin, 1'b0);
    wait_cnt(260); chk("i2s_r0", audio_sdin, 1'b0);
    wait_cnt(268); chk("i2s_r1", audio_sdin, 1'b0);
    wait_cnt(276); chk("i2s_r2", audio_sdin, 1'b1);
`endif
    wait_cnt(400);
    audio_left = 16'hFFFF;
    wait_cnt(100);
    audio_left = 16'h0000;
    wait_cnt(120); chk("hold_cur", audio_sdin, 1'b1);
    wait_cnt(120); chk("hold_next", audio_sdin, 1'b0);
    repeat (40) begin
      repeat ($urandom_range(1, 400)) @(negedge clk);
      audio_left = W'($urandom);
      audio_right = W'($urandom);
    end
    wait_cnt(400);
    audio_right = 16'hFFFF;
    wait_cnt(300); chk("pre_rst_sdin", audio_sdin, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sdin", audio_sdin, 1'b0);
    chk("mid_rst_lrck", audio_lrck, 1'b0);
    chk("mid_rst_sck", audio_sck, 1'b0);
    chk("mid_rst_mclk", audio_mclk, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(300); chk("zero_frame", audio_sdin, 1'b0);
    wait_cnt(300); chk("resume_frame", audio_sdin, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
